seq_event_logger: RTL and testbench
===================================

# seq_event_logger

Downstream consumer of the three-ones sequence detector's level output. Converts the detector's "held high while the run of ones continues" level into a one-cycle event pulse per detection run. Counts detections, measures each run's duration in cycles, and flags any run that reaches a programmable length threshold. It sits between the detector and the status/register logic, on the same clock and reset.

## Interface
- CNT_W, 8, width of the detection event counter
- LEN_W, 8, width of the run-length counter and captured run length
- LONG_THRESH, 16, run length (cycles of det high) at which long_run sets; legal range 1 .. 2^LEN_W-1

- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- det  input  1  detector output level (high while detector is in its "three or more ones" state)
- clr  input  1  synchronous clear of evt_count, long_run, run_len
- evt  output  1  one-cycle pulse per detection run
- evt_count  output  CNT_W  number of detection runs since reset/clr, saturating
- run_len  output  LEN_W  duration of the most recently completed run, saturating
- run_valid  output  1  one-cycle pulse when run_len is updated
- long_run  output  1  sticky flag: some run reached LONG_THRESH cycles

## Operation
- Two-state FSM: IDLE, ACTIVE. Internal len_cnt (LEN_W bits).
- IDLE, det=0: stay IDLE. No output change.
- IDLE, det=1: go ACTIVE.
  - evt<=1.
  - evt_count<=evt_count+1, saturating at 2^CNT_W-1.
  - len_cnt<=1.
  - If LONG_THRESH==1, long_run<=1.
- ACTIVE, det=1: stay ACTIVE.
  - len_cnt<=len_cnt+1, saturating at 2^LEN_W-1.
  - If len_cnt+1==LONG_THRESH, long_run<=1.
- ACTIVE, det=0: go IDLE.
  - run_len<=len_cnt.
  - run_valid<=1.
  - len_cnt<=0.
- evt and run_valid are 0 in every cycle not listed above.
- Run length equals the number of rising edges at which det was sampled high. For a detector input of N consecutive ones (N≥3), run length is N-2.
- long_run is sticky. It clears only on rst or clr.
- clr priority:
  - clr forces evt_count<=0 and long_run<=0, overriding any increment or set in the same cycle.
  - clr forces run_len<=0 unless a run completes in the same cycle; in that case the captured len_cnt wins.
  - clr does not affect the FSM, len_cnt, evt or run_valid. A run in progress keeps being measured.
- A run longer than 2^LEN_W-1 reports run_len=2^LEN_W-1.

## Timing
- All outputs are registered. Reset values: state=IDLE, len_cnt=0, evt=0, evt_count=0, run_len=0, run_valid=0, long_run=0.
- Reset is asynchronous. Asserting rst mid-run drops the run immediately: no run_valid, no run_len update. After release, a det already high is treated as a new rising edge, so evt pulses and the count increments.
- Latency:
  - evt is high in the cycle after the first rising edge that samples det=1.
  - run_valid is high in the cycle after the first rising edge that samples det=0 following a run.
  - evt_count and run_len change in the same cycle as their respective pulse.
- Back-to-back runs: det pattern 1,0,1 yields evt, then run_valid, then evt on three consecutive cycles. Every transition is handled with no dead cycle.
- det must be synchronous to clk. The detector output already is, so no synchronizer is needed.

## Test plan
- Reset: hold det=1 for 4 cycles, assert rst mid-run for 2 cycles, release with det=1.
  - All outputs 0 during rst, and no run_valid.
  - One evt 1 cycle after release, evt_count=1.
- Single run: det high for exactly 5 sampled edges, then low.
  - evt for 1 cycle, evt_count=1.
  - run_valid for 1 cycle with run_len=5, long_run=0.
- Back-to-back: det 1,0,1,0 on consecutive edges.
  - Pulses evt, run_valid, evt, run_valid on consecutive cycles.
  - evt_count=2, run_len=1.
- Long run (LONG_THRESH=16): det high for 20 edges.
  - long_run rises 1 cycle after the 16th high edge and stays set after the run ends.
  - run_len=20.
  - clr then gives long_run=0, evt_count=0, run_len=0.
- Saturation (CNT_W=8, LEN_W=8):
  - 260 single-cycle runs give evt_count=255.
  - One run of 300 cycles gives run_len=255.
- Simultaneous events:
  - clr on the same edge as an IDLE→ACTIVE transition: evt still pulses and evt_count=0 afterwards.
  - clr on the same edge as a run end of length 7: run_valid pulses with run_len=7.

Source files
------------

// File: rtl/seq_event_logger_if.sv
// Bundle of the detector-level input, clear strobe and logger status
// outputs exchanged between the sequence detector side and the logger.
// The master drives det/clr and observes the status; the slave is the logger.
interface seq_event_logger_if #(
    parameter int CNT_W = 8,
    parameter int LEN_W = 8
);
    logic             det;
    logic             clr;
    logic             evt;
    logic [CNT_W-1:0] evt_count;
    logic [LEN_W-1:0] run_len;
    logic             run_valid;
    logic             long_run;

    modport master (
        output det,
        output clr,
        input  evt,
        input  evt_count,
        input  run_len,
        input  run_valid,
        input  long_run
    );

    modport slave (
        input  det,
        input  clr,
        output evt,
        output evt_count,
        output run_len,
        output run_valid,
        output long_run
    );
endinterface

// File: rtl/seq_event_logger.sv
// Sequence detection event logger.
// Turns the detector's held-high level into one evt pulse per run, counts
// runs (saturating), measures each run's length in sampled-high cycles
// (saturating) and keeps a sticky flag once any run reaches LONG_THRESH.
// LONG_THRESH is expected in 1 .. 2^LEN_W-1.
module seq_event_logger #(
    parameter int CNT_W       = 8,
    parameter int LEN_W       = 8,
    parameter int LONG_THRESH = 16
) (
    input  logic                clk,
    input  logic                rst,
    seq_event_logger_if.slave   bus
);

    // Two-state FSM encoding
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_MAX  = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1'b1);

    // Threshold held one bit wider so len_cnt+1 never wraps into a false match
    localparam logic [LEN_W:0]   THRESH_EXT = (LEN_W+1)'(LONG_THRESH);
    localparam logic [LEN_W:0]   EXT_ONE    = (LEN_W+1)'(1'b1);

    // Saturating increment of the run counter
    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_W'(1'b1);
        end
        return r;
    endfunction

    // Saturating increment of the run-length counter
    function automatic logic [LEN_W-1:0] sat_inc_len(input logic [LEN_W-1:0] v);
        logic [LEN_W-1:0] r;
        if (v == LEN_MAX) begin
            r = v;
        end else begin
            r = v + LEN_ONE;
        end
        return r;
    endfunction

    logic [0:0]       state_q,     state_d;
    logic [LEN_W-1:0] len_cnt_q,   len_cnt_d;
    logic             evt_q,       evt_d;
    logic [CNT_W-1:0] evt_count_q, evt_count_d;
    logic [LEN_W-1:0] run_len_q,   run_len_d;
    logic             run_valid_q, run_valid_d;
    logic             long_run_q,  long_run_d;

    logic             run_end_s;
    logic [LEN_W:0]   len_next_ext_s;

    assign len_next_ext_s = {1'b0, len_cnt_q} + EXT_ONE;

    // Next-state and output computation for the IDLE/ACTIVE run tracker
    always_comb begin
        state_d     = state_q;
        len_cnt_d   = len_cnt_q;
        evt_d       = 1'b0;
        evt_count_d = evt_count_q;
        run_len_d   = run_len_q;
        run_valid_d = 1'b0;
        long_run_d  = long_run_q;
        run_end_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.det) begin
                    state_d     = ST_ACTIVE;
                    evt_d       = 1'b1;
                    evt_count_d = sat_inc_cnt(evt_count_q);
                    len_cnt_d   = LEN_ONE;
                    if (THRESH_EXT == EXT_ONE) begin
                        long_run_d = 1'b1;
                    end else begin
                        long_run_d = long_run_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (bus.det) begin
                    state_d   = ST_ACTIVE;
                    len_cnt_d = sat_inc_len(len_cnt_q);
                    if (len_next_ext_s == THRESH_EXT) begin
                        long_run_d = 1'b1;
                    end else begin
                        long_run_d = long_run_q;
                    end
                end else begin
                    state_d     = ST_IDLE;
                    run_len_d   = len_cnt_q;
                    run_valid_d = 1'b1;
                    len_cnt_d   = LEN_ZERO;
                    run_end_s   = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                len_cnt_d = LEN_ZERO;
            end
        endcase

        // Clear wipes the status but never the run being measured; a run
        // completing on the same edge still reports its captured length.
        if (bus.clr) begin
            evt_count_d = CNT_ZERO;
            long_run_d  = 1'b0;
            if (run_end_s) begin
                run_len_d = len_cnt_q;
            end else begin
                run_len_d = LEN_ZERO;
            end
        end else begin
            evt_count_d = evt_count_d;
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_cnt_q   <= LEN_ZERO;
            evt_q       <= 1'b0;
            evt_count_q <= CNT_ZERO;
            run_len_q   <= LEN_ZERO;
            run_valid_q <= 1'b0;
            long_run_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_cnt_q   <= len_cnt_d;
            evt_q       <= evt_d;
            evt_count_q <= evt_count_d;
            run_len_q   <= run_len_d;
            run_valid_q <= run_valid_d;
            long_run_q  <= long_run_d;
        end
    end

    assign bus.evt       = evt_q;
    assign bus.evt_count = evt_count_q;
    assign bus.run_len   = run_len_q;
    assign bus.run_valid = run_valid_q;
    assign bus.long_run  = long_run_q;

endmodule

// File: tb/tb_seq_event_logger.sv
// Bench for seq_event_logger: table vectors with hand-derived expectations,
// then model-driven sequences for long runs, saturation and mid-run reset.
module tb_seq_event_logger;
    localparam int CNT_W = 8;
    localparam int LEN_W = 8;
    localparam int TH    = 16;
    localparam int NVEC  = 22;

    typedef struct packed {
        logic       evt;
        logic [7:0] cnt;
        logic [7:0] rl;
        logic       rv;
        logic       lr;
    } exp_t;

    typedef struct {
        logic det;
        logic clr;
        exp_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    seq_event_logger_if #(.CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

    seq_event_logger #(.CNT_W(CNT_W), .LEN_W(LEN_W), .LONG_THRESH(TH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];
    string name_q[$];
    vec_t tbl[NVEC];

    // reference model state
    logic       m_prev;
    logic [7:0] m_cnt;
    logic [7:0] m_len;
    logic [7:0] m_rl;
    logic       m_long;

    function automatic exp_t observed();
        exp_t o;
        o = {bus.evt, bus.evt_count, bus.run_len, bus.run_valid, bus.long_run};
        return o;
    endfunction

    function automatic vec_t mk(input logic d, input logic c, input logic e,
                                input logic [7:0] cnt, input logic [7:0] rl,
                                input logic rv, input logic lr);
        vec_t v;
        v.det = d;
        v.clr = c;
        v.exp = {e, cnt, rl, rv, lr};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, want);
    endtask

    task automatic check_out(input string name, input exp_t got, input exp_t want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got evt=%0b cnt=%0d len=%0d rv=%0b lr=%0b expected evt=%0b cnt=%0d len=%0d rv=%0b lr=%0b",
                      name, got.evt, got.cnt, got.rl, got.rv, got.lr,
                      want.evt, want.cnt, want.rl, want.rv, want.lr);
    endtask

    // drive one cycle, queue its expectation, compare after the edge
    task automatic apply(input logic d, input logic c, input exp_t e, input string name);
        exp_t w;
        string nm;
        bus.det = d;
        bus.clr = c;
        exp_q.push_back(e);
        name_q.push_back(name);
        @(posedge clk);
        #1;
        w  = exp_q.pop_front();
        nm = name_q.pop_front();
        check_out(nm, observed(), w);
    endtask

    task automatic model_reset();
        m_prev = 1'b0;
        m_cnt  = 8'd0;
        m_len  = 8'd0;
        m_rl   = 8'd0;
        m_long = 1'b0;
    endtask

    // behavioural model: runs are delimited by edges of the sampled det
    task automatic model_step(input logic d, input logic c, input string name);
        logic e_evt;
        logic e_rv;
        e_evt = d && !m_prev;
        e_rv  = !d && m_prev;
        if (e_evt) begin
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            m_len = 8'd1;
            if (TH == 1) m_long = 1'b1;
        end
        if (d && m_prev) begin
            if (m_len != 8'hFF) m_len = m_len + 8'd1;
            if (int'(m_len) == TH) m_long = 1'b1;
        end
        if (e_rv) begin
            m_rl  = m_len;
            m_len = 8'd0;
        end
        if (c) begin
            m_cnt  = 8'd0;
            m_long = 1'b0;
            if (!e_rv) m_rl = 8'd0;
        end
        m_prev = d;
        apply(d, c, {e_evt, m_cnt, m_rl, e_rv, m_long}, name);
    endtask

    initial begin
        // single run of 5, then 1,0,1,0 back-to-back, then clr coincidences
        tbl[0]  = mk(1'b1, 1'b0, 1'b1, 8'd1, 8'd0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 1'b0, 1'b0);
        tbl[3]  = mk(1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 1'b0, 1'b0);
        tbl[4]  = mk(1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 1'b0, 1'b0, 8'd1, 8'd5, 1'b1, 1'b0);
        tbl[6]  = mk(1'b0, 1'b0, 1'b0, 8'd1, 8'd5, 1'b0, 1'b0);
        tbl[7]  = mk(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        tbl[8]  = mk(1'b1, 1'b0, 1'b1, 8'd1, 8'd0, 1'b0, 1'b0);
        tbl[9]  = mk(1'b0, 1'b0, 1'b0, 8'd1, 8'd1, 1'b1, 1'b0);
        tbl[10] = mk(1'b1, 1'b0, 1'b1, 8'd2, 8'd1, 1'b0, 1'b0);
        tbl[11] = mk(1'b0, 1'b0, 1'b0, 8'd2, 8'd1, 1'b1, 1'b0);
        tbl[12] = mk(1'b0, 1'b0, 1'b0, 8'd2, 8'd1, 1'b0, 1'b0);
        tbl[13] = mk(1'b1, 1'b1, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0);
        for (int i = 14; i < 20; i++) tbl[i] = mk(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        tbl[20] = mk(1'b0, 1'b1, 1'b0, 8'd0, 8'd7, 1'b1, 1'b0);
        tbl[21] = mk(1'b0, 1'b0, 1'b0, 8'd0, 8'd7, 1'b0, 1'b0);

        rst     = 1'b1;
        bus.det = 1'b0;
        bus.clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_state", observed(), 19'd0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            apply(tbl[i].det, tbl[i].clr, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // fresh start for the model-driven part
        rst = 1'b1;
        bus.det = 1'b0;
        bus.clr = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // long run crossing the threshold
        for (int i = 0; i < 20; i++) begin
            model_step(1'b1, 1'b0, "long_hi");
            if (i == 14) check("long_before_thresh", 32'(bus.long_run), 32'd0);
            if (i == 15) check("long_at_thresh", 32'(bus.long_run), 32'd1);
        end
        model_step(1'b0, 1'b0, "long_end");
        check("long_run_len", 32'(bus.run_len), 32'd20);
        check("long_sticky", 32'(bus.long_run), 32'd1);
        model_step(1'b0, 1'b1, "long_clr");
        check("clr_long", 32'(bus.long_run), 32'd0);
        check("clr_cnt", 32'(bus.evt_count), 32'd0);
        check("clr_len", 32'(bus.run_len), 32'd0);

        // run-counter saturation
        for (int i = 0; i < 260; i++) begin
            model_step(1'b1, 1'b0, "sat_cnt_hi");
            model_step(1'b0, 1'b0, "sat_cnt_lo");
        end
        check("cnt_saturated", 32'(bus.evt_count), 32'd255);

        // run-length saturation
        for (int i = 0; i < 300; i++) model_step(1'b1, 1'b0, "sat_len_hi");
        model_step(1'b0, 1'b0, "sat_len_end");
        check("len_saturated", 32'(bus.run_len), 32'd255);

        // reset in the middle of a run
        model_step(1'b0, 1'b1, "pre_rst_clr");
        for (int i = 0; i < 4; i++) model_step(1'b1, 1'b0, "pre_rst_hi");
        rst = 1'b1;
        #1;
        check_out("rst_async", observed(), 19'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_out("rst_hold", observed(), 19'd0);
        end
        rst = 1'b0;
        model_reset();
        model_step(1'b1, 1'b0, "post_rst_evt");
        check("post_rst_evt", 32'(bus.evt), 32'd1);
        check("post_rst_cnt", 32'(bus.evt_count), 32'd1);
        model_step(1'b1, 1'b0, "post_rst_hi");
        model_step(1'b0, 1'b0, "post_rst_end");
        check("post_rst_len", 32'(bus.run_len), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
